sram_arbiter: RTL and testbench

- Shares the single external video SRAM between three requesters: VGA scanout reads (highest priority), text-renderer glyph writes/reads, and a screen-clear fill engine (writes).
- Owns all SRAM pins and serialises one access at a time with a fixed multi-cycle access window.
- Returns a one-cycle completion pulse, plus read data where applicable, to the requester that won.
- Sits between the renderer/scanout logic and the SRAM pad ring.

---
 rtl/sram_arbiter_pkg.sv | 23 ++
 rtl/rr_pick2.sv | 19 +
 rtl/sram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the video SRAM arbiter.
//   ArbOwner_t         : which requester holds the SRAM bus
//   ArbState_t         : arbiter FSM states
//   SRAM_ACCESS_CYCLES : default bus hold time per access
//   ARB_CNT_W          : width of the access-cycle counter
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_VGA,
    OWNER_REN,
    OWNER_CLR
  } ArbOwner_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_DONE
  } ArbState_t;

  localparam int unsigned SRAM_ACCESS_CYCLES = 2;
  localparam int unsigned ARB_CNT_W          = 3;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
//   req_a, req_b     : request lines
//   last             : 1 = b was granted most recently, 0 = a was
//   grant_a, grant_b : one-hot (or zero) grant
// A lone requester always wins; on a tie the side not granted last wins.
module rr_pick2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic grant_a,
  output logic grant_b
);

  always_comb begin
    grant_a = req_a && (!req_b || last);
    grant_b = req_b && (!req_a || !last);
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one external video SRAM between VGA scanout reads (strict
// priority), renderer reads/writes and clear-engine writes. One access at a
// time, held on the bus for ACCESS_CYCLES cycles, followed by a one-cycle
// done pulse (plus read data) to the winner.
//   clk, rst                 : clock, asynchronous active-high reset
//   vga_req/addr/rdata/done  : scanout read port
//   ren_req/wren/addr/wdata/rdata/done : renderer port
//   clr_req/addr/wdata/done  : clear-engine write port
//   sram_*                   : SRAM pad-side pins (controls active-low)
//   busy                     : arbiter not idle
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 20,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ACCESS_CYCLES = SRAM_ACCESS_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  output logic                  vga_done,
  input  logic                  ren_req,
  input  logic                  ren_wren,
  input  logic [ADDR_WIDTH-1:0] ren_addr,
  input  logic [DATA_WIDTH-1:0] ren_wdata,
  output logic [DATA_WIDTH-1:0] ren_rdata,
  output logic                  ren_done,
  input  logic                  clr_req,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [DATA_WIDTH-1:0] clr_wdata,
  output logic                  clr_done,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  sram_data_oe,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  busy
);

  if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 7) begin : g_bad_access_cycles
    $error("sram_arbiter: ACCESS_CYCLES must be in 2..7");
  end

  localparam logic [ARB_CNT_W-1:0] CNT_LAST = ARB_CNT_W'(ACCESS_CYCLES - 1);

  ArbState_t             state_q, state_d;
  ArbOwner_t             owner_q, owner_d;
  ArbOwner_t             rr_last_q, rr_last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wren_q, wren_d;
  logic [ARB_CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] vga_rdata_q, vga_rdata_d;
  logic [DATA_WIDTH-1:0] ren_rdata_q, ren_rdata_d;

  logic grant_ren, grant_clr;
  logic in_access;

  rr_pick2 u_rr (
    .req_a   (ren_req),
    .req_b   (clr_req),
    .last    (rr_last_q == OWNER_CLR),
    .grant_a (grant_ren),
    .grant_b (grant_clr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWNER_VGA;
      rr_last_q   <= OWNER_CLR;
      addr_q      <= '0;
      wdata_q     <= '0;
      wren_q      <= 1'b0;
      cnt_q       <= '0;
      vga_rdata_q <= '0;
      ren_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wren_q      <= wren_d;
      cnt_q       <= cnt_d;
      vga_rdata_q <= vga_rdata_d;
      ren_rdata_q <= ren_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wren_d      = wren_q;
    cnt_d       = cnt_q;
    vga_rdata_d = vga_rdata_q;
    ren_rdata_d = ren_rdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (vga_req) begin
          owner_d = OWNER_VGA;
          addr_d  = vga_addr;
          wren_d  = 1'b0;
          state_d = ARB_ACCESS;
        end else if (grant_ren) begin
          owner_d   = OWNER_REN;
          addr_d    = ren_addr;
          wdata_d   = ren_wdata;
          wren_d    = ren_wren;
          rr_last_d = OWNER_REN;
          state_d   = ARB_ACCESS;
        end else if (grant_clr) begin
          owner_d   = OWNER_CLR;
          addr_d    = clr_addr;
          wdata_d   = clr_wdata;
          wren_d    = 1'b1;
          rr_last_d = OWNER_CLR;
          state_d   = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ARB_DONE;
          // Read data is captured straight into the owner's output register
          // so it is valid during DONE and holds until that owner's next read.
          if (!wren_q) begin
            if (owner_q == OWNER_VGA) vga_rdata_d = sram_rdata;
            if (owner_q == OWNER_REN) ren_rdata_d = sram_rdata;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  assign in_access = (state_q == ARB_ACCESS);

  always_comb begin
    sram_addr    = addr_q;
    sram_wdata   = wdata_q;
    sram_ce_n    = !in_access;
    sram_oe_n    = !(in_access && !wren_q);
    sram_data_oe = in_access && wren_q;
    // WE released on the final access cycle so write data is held past it.
    sram_we_n    = !(in_access && wren_q && (cnt_q != CNT_LAST));
    vga_done     = (state_q == ARB_DONE) && (owner_q == OWNER_VGA);
    ren_done     = (state_q == ARB_DONE) && (owner_q == OWNER_REN);
    clr_done     = (state_q == ARB_DONE) && (owner_q == OWNER_CLR);
    vga_rdata    = vga_rdata_q;
    ren_rdata    = ren_rdata_q;
    busy         = (state_q != ARB_IDLE);
  end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int AC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vga_req = 1'b0, ren_req = 1'b0, ren_wren = 1'b0, clr_req = 1'b0;
  logic [AW-1:0] vga_addr = '0, ren_addr = '0, clr_addr = '0;
  logic [DW-1:0] ren_wdata = '0, clr_wdata = '0, sram_rdata = '0;
  logic [DW-1:0] vga_rdata, ren_rdata, sram_wdata;
  logic          vga_done, ren_done, clr_done;
  logic [AW-1:0] sram_addr;
  logic          sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n, busy;

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_done(vga_done),
    .ren_req(ren_req), .ren_wren(ren_wren), .ren_addr(ren_addr), .ren_wdata(ren_wdata),
    .ren_rdata(ren_rdata), .ren_done(ren_done),
    .clr_req(clr_req), .clr_addr(clr_addr), .clr_wdata(clr_wdata), .clr_done(clr_done),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_data_oe(sram_data_oe),
    .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] wdata; logic wren; } txn_t;
  typedef struct {
    int owner; logic wren; logic [AW-1:0] addr; logic [DW-1:0] wdata;
    logic chk_rd; logic [DW-1:0] rd;
  } exp_t;

  txn_t vq[$], rq[$], cq[$];
  exp_t sb[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  int checks = 0, errors = 0, cyc = 0;
  int grant_log[$];
  bit log_grants = 0, vga_gap = 0, vga_hold = 0;

  function automatic logic [DW-1:0] mem_rd(logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(int who, logic [AW-1:0] a, logic [DW-1:0] d, logic w);
    txn_t t;
    t.addr = a; t.wdata = d; t.wren = w;
    if (who == 0) vq.push_back(t);
    else if (who == 1) rq.push_back(t);
    else cq.push_back(t);
  endtask

  task automatic expect_done(int who, logic w, logic [AW-1:0] a, logic [DW-1:0] d,
                             logic chk_rd, logic [DW-1:0] rd);
    exp_t e;
    e.owner = who; e.wren = w; e.addr = a; e.wdata = d; e.chk_rd = chk_rd; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic wait_drain(string name, int budget);
    int n;
    n = 0;
    while ((sb.size() > 0 || vq.size() > 0 || rq.size() > 0 || cq.size() > 0 || busy)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_in_time"}, (n < budget) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // SRAM model: write strobe sampled at the clock edge
  initial forever begin
    @(posedge clk);
    if (!sram_ce_n && !sram_we_n && sram_data_oe) mem[sram_addr] = sram_wdata;
  end

  // Requester drivers: hold req until own done, then drop / present next
  initial forever begin
    @(negedge clk);
    if (vga_req && vga_done) begin
      void'(vq.pop_front()); vga_req = 1'b0; vga_hold = vga_gap;
    end else if (!vga_req && vq.size() > 0) begin
      if (vga_hold) vga_hold = 1'b0;
      else begin vga_req = 1'b1; vga_addr = vq[0].addr; end
    end
    if (ren_req && ren_done) begin
      void'(rq.pop_front()); ren_req = 1'b0;
    end else if (!ren_req && rq.size() > 0) begin
      ren_req = 1'b1; ren_addr = rq[0].addr; ren_wdata = rq[0].wdata; ren_wren = rq[0].wren;
    end
    if (clr_req && clr_done) begin
      void'(cq.pop_front()); clr_req = 1'b0;
    end else if (!clr_req && cq.size() > 0) begin
      clr_req = 1'b1; clr_addr = cq[0].addr; clr_wdata = cq[0].wdata;
    end
  end

  // Monitor: SRAM read data, pin activity per access, completion scoreboard
  initial begin
    int ce_c, oe_c, we_c, doe_c, addr_bad, wd_bad, grant_cyc, nd, act_owner;
    bit busy_prev;
    exp_t e;
    ce_c = 0; oe_c = 0; we_c = 0; doe_c = 0; addr_bad = 0; wd_bad = 0;
    grant_cyc = 0; busy_prev = 0;
    forever begin
      @(negedge clk);
      cyc++;
      sram_rdata = (!sram_ce_n && !sram_oe_n) ? mem_rd(sram_addr) : '0;
      if (rst) begin
        ce_c = 0; oe_c = 0; we_c = 0; doe_c = 0; addr_bad = 0; wd_bad = 0; busy_prev = 0;
      end else begin
        if (busy && !busy_prev) begin
          grant_cyc = cyc;
          if (log_grants) grant_log.push_back(cyc);
        end
        busy_prev = busy;
        if (!sram_ce_n) begin
          ce_c++;
          if (sb.size() > 0 && sram_addr !== sb[0].addr) addr_bad++;
        end
        if (!sram_oe_n) oe_c++;
        if (!sram_we_n) we_c++;
        if (sram_data_oe) begin
          doe_c++;
          if (sb.size() > 0 && sram_wdata !== sb[0].wdata) wd_bad++;
        end
        nd = int'(vga_done) + int'(ren_done) + int'(clr_done);
        if (nd > 0) begin
          chk("single_done", nd, 1);
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done v/r/c=%b%b%b expected none (t=%0t)",
                     vga_done, ren_done, clr_done, $time);
          end else begin
            e = sb.pop_front();
            act_owner = vga_done ? 0 : (ren_done ? 1 : 2);
            chk("grant_owner", act_owner, e.owner);
            chk("done_latency", cyc - grant_cyc, AC);
            chk("ce_cycles", ce_c, AC);
            chk("addr_on_bus", addr_bad, 0);
            chk("oe_cycles", oe_c, e.wren ? 0 : AC);
            chk("we_cycles", we_c, e.wren ? AC - 1 : 0);
            chk("data_oe_cycles", doe_c, e.wren ? AC : 0);
            if (e.wren) chk("wdata_on_bus", wd_bad, 0);
            if (e.chk_rd) chk("rdata", (act_owner == 0) ? vga_rdata : ren_rdata, e.rd);
          end
          ce_c = 0; oe_c = 0; we_c = 0; doe_c = 0; addr_bad = 0; wd_bad = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    mem[20'h12345] = 32'hDEADBEEF;
    mem[20'h00300] = 32'hCAFEF00D;

    // Reset held with all three requesting; vga first, then ren (rr_last=CLR), then clr
    add(0, 20'h12345, '0, 1'b0);
    add(1, 20'h00100, 32'hA5A5A5A5, 1'b1);
    add(2, 20'h00200, 32'h11111111, 1'b1);
    repeat (3) begin
      @(negedge clk); #1;
      chk("reset_pins_ce_oe_we_doe_done_busy",
          {sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, vga_done, ren_done, clr_done, busy},
          8'b1110_0000);
      chk("reset_sram_addr", sram_addr, 0);
      chk("reset_rdata", vga_rdata | ren_rdata, 0);
    end
    expect_done(0, 1'b0, 20'h12345, '0, 1'b1, 32'hDEADBEEF);
    expect_done(1, 1'b1, 20'h00100, 32'hA5A5A5A5, 1'b1, 32'h0);
    expect_done(2, 1'b1, 20'h00200, 32'h11111111, 1'b0, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("first_grant_busy", busy, 1);
    chk("first_grant_addr", sram_addr, 20'h12345);
    chk("first_grant_read_oe_n", sram_oe_n, 0);
    wait_drain("t1", 40);
    chk("mem_ren_write", mem_rd(20'h00100), 32'hA5A5A5A5);
    chk("mem_clr_write", mem_rd(20'h00200), 32'h11111111);

    // Lone requesters
    add(0, 20'h00300, '0, 1'b0);
    expect_done(0, 1'b0, 20'h00300, '0, 1'b1, 32'hCAFEF00D);
    wait_drain("lone_vga", 20);
    add(1, 20'h00100, '0, 1'b0);
    expect_done(1, 1'b0, 20'h00100, '0, 1'b1, 32'hA5A5A5A5);
    wait_drain("lone_ren_read", 20);
    add(2, 20'h00201, 32'h22222222, 1'b1);
    expect_done(2, 1'b1, 20'h00201, 32'h22222222, 1'b0, '0);
    wait_drain("lone_clr", 20);

    // ren/clr contending continuously: strict alternation, one access per 4 cycles
    log_grants = 1;
    for (int i = 0; i < 3; i++) begin
      add(1, 20'h00400 + 20'(i), 32'h40000000 + 32'(i), 1'b1);
      add(2, 20'h00500 + 20'(i), 32'h50000000 + 32'(i), 1'b1);
      expect_done(1, 1'b1, 20'h00400 + 20'(i), 32'h40000000 + 32'(i), 1'b1, 32'hA5A5A5A5);
      expect_done(2, 1'b1, 20'h00500 + 20'(i), 32'h50000000 + 32'(i), 1'b0, '0);
    end
    wait_drain("alternate", 60);
    log_grants = 0;
    chk("alternate_grant_count", grant_log.size(), 6);
    for (int i = 1; i < 6; i++)
      if (i < grant_log.size()) chk("alternate_grant_spacing", grant_log[i] - grant_log[i-1], 4);
    chk("mem_alt_last", mem_rd(20'h00502), 32'h50000002);

    // All three in the same cycle: vga, ren, clr
    add(0, 20'h12345, '0, 1'b0);
    add(1, 20'h00600, 32'h00000066, 1'b1);
    add(2, 20'h00700, 32'h00000077, 1'b1);
    expect_done(0, 1'b0, 20'h12345, '0, 1'b1, 32'hDEADBEEF);
    expect_done(1, 1'b1, 20'h00600, 32'h00000066, 1'b1, 32'hA5A5A5A5);
    expect_done(2, 1'b1, 20'h00700, 32'h00000077, 1'b0, '0);
    wait_drain("three_way", 40);

    // vga re-asserts between other accesses: V R V C V R V C
    vga_gap = 1;
    add(0, 20'h12345, '0, 1'b0);
    add(0, 20'h00300, '0, 1'b0);
    add(0, 20'h12345, '0, 1'b0);
    add(0, 20'h00300, '0, 1'b0);
    add(1, 20'h00610, 32'h00000610, 1'b1);
    add(1, 20'h00611, 32'h00000611, 1'b1);
    add(2, 20'h00710, 32'h00000710, 1'b1);
    add(2, 20'h00711, 32'h00000711, 1'b1);
    expect_done(0, 1'b0, 20'h12345, '0, 1'b1, 32'hDEADBEEF);
    expect_done(1, 1'b1, 20'h00610, 32'h00000610, 1'b1, 32'hA5A5A5A5);
    expect_done(0, 1'b0, 20'h00300, '0, 1'b1, 32'hCAFEF00D);
    expect_done(2, 1'b1, 20'h00710, 32'h00000710, 1'b0, '0);
    expect_done(0, 1'b0, 20'h12345, '0, 1'b1, 32'hDEADBEEF);
    expect_done(1, 1'b1, 20'h00611, 32'h00000611, 1'b1, 32'hA5A5A5A5);
    expect_done(0, 1'b0, 20'h00300, '0, 1'b1, 32'hCAFEF00D);
    expect_done(2, 1'b1, 20'h00711, 32'h00000711, 1'b0, '0);
    wait_drain("vga_interleave", 80);
    vga_gap = 0;
    chk("mem_interleave", mem_rd(20'h00711), 32'h00000711);

    // Reset during the first cycle of a write: pins idle at once, no done, no write
    add(1, 20'h00800, 32'h88888888, 1'b1);
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (sram_data_oe) found = 1;
    end
    chk("abort_access_reached", found, 1);
    rst = 1'b1;
    #1;
    chk("abort_pins_ce_oe_we_doe_busy",
        {sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, busy}, 5'b11100);
    chk("abort_bus_addr_data", {12'h0, sram_addr} | sram_wdata, 0);
    chk("abort_rdata_cleared", vga_rdata | ren_rdata, 0);
    repeat (2) begin
      @(negedge clk); #1;
      chk("abort_no_done", {vga_done, ren_done, clr_done}, 3'b000);
    end
    chk("abort_no_write", mem_rd(20'h00800), 0);
    expect_done(1, 1'b1, 20'h00800, 32'h88888888, 1'b1, 32'h0);
    rst = 1'b0;
    wait_drain("after_abort", 20);
    chk("mem_after_abort", mem_rd(20'h00800), 32'h88888888);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
